// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: qualifies lock, retries on timeout, sticky fail,
// and releases per-output-clock domain resets in staggered order.
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 64,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int N_DOM         = 5,
    parameter int STAGGER       = 16
) (
    input  logic             clkin1,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             restart,
    output logic             pll_rst,
    output logic [N_DOM-1:0] dom_rst_n,
    output logic             ready,
    output logic             fail,
    output logic [3:0]       retry_cnt,
    output logic [7:0]       loss_cnt,
    output logic [2:0]       state
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (STABLE_CYCLES > STAGGER * N_DOM) ? STABLE_CYCLES : STAGGER * N_DOM;
    localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_V) + 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    // RUN is entered one cycle after the last domain bit has been released
    localparam logic [CW-1:0] REL_LAST = CW'(STAGGER * N_DOM);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    state_t          st;
    logic [1:0]      sync;
    logic            lock_s;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [N_DOM-1:0] rel_hit;

    assign lock_s  = sync[1];
    assign cnt_inc = cnt + CW'(1);
    assign state   = st;

    // bit i releases STAGGER*(i+1) cycles after RELEASE entry
    for (genvar i = 0; i < N_DOM; i++) begin : g_rel
        assign rel_hit[i] = (cnt_inc >= CW'(STAGGER * (i + 1)));
    end

    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= '0;
            st        <= S_RESET;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            dom_rst_n <= '0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            sync <= {sync[0], pll_lock};
            if (restart) begin
                st        <= S_RESET;
                cnt       <= '0;
                pll_rst   <= 1'b1;
                dom_rst_n <= '0;
                ready     <= 1'b0;
                fail      <= 1'b0;
                retry_cnt <= '0;
            end else begin
                case (st)
                    S_RESET: begin
                        if (cnt == RST_LAST) begin
                            st      <= S_WAIT;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_WAIT: begin
                        if (lock_s) begin
                            st  <= S_STABLE;
                            cnt <= '0;
                        end else if (cnt == TO_LAST) begin
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                            if (retry_cnt == 4'(MAX_RETRY)) begin
                                st   <= S_FAIL;
                                fail <= 1'b1;
                            end else begin
                                st        <= S_RESET;
                                retry_cnt <= retry_cnt + 4'd1;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_STABLE: begin
                        // chatter before qualification is not a loss event
                        if (!lock_s) begin
                            st  <= S_WAIT;
                            cnt <= '0;
                        end else if (cnt == STB_LAST) begin
                            st  <= S_RELEASE;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_RELEASE, S_RUN: begin
                        if (!lock_s) begin
                            st        <= S_RESET;
                            cnt       <= '0;
                            pll_rst   <= 1'b1;
                            dom_rst_n <= '0;
                            ready     <= 1'b0;
                            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
                        end else if (st == S_RELEASE) begin
                            if (cnt == REL_LAST) begin
                                st        <= S_RUN;
                                cnt       <= '0;
                                ready     <= 1'b1;
                                retry_cnt <= '0;
                            end else begin
                                cnt       <= cnt_inc;
                                dom_rst_n <= dom_rst_n | rel_hit;
                            end
                        end
                    end
                    S_FAIL: begin
                        pll_rst   <= 1'b1;
                        fail      <= 1'b1;
                        dom_rst_n <= '0;
                    end
                    default: begin
                        st        <= S_RESET;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        dom_rst_n <= '0;
                        ready     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scenario bench for pll_lock_ctrl; expected waveforms derived from phase
// lengths (reset, timeout, stable window, stagger) with plain arithmetic.
module tb_pll_lock_ctrl;

    localparam int RST_C = 4;
    localparam int TO_C  = 32;
    localparam int STB_C = 8;
    localparam int MAX_R = 2;
    localparam int N_DOM = 5;
    localparam int STAG  = 2;

    logic             clkin1 = 1'b0;
    logic             rst_n = 1'b0;
    logic             pll_lock = 1'b0;
    logic             restart = 1'b0;
    logic             pll_rst;
    logic [N_DOM-1:0] dom_rst_n;
    logic             ready;
    logic             fail;
    logic [3:0]       retry_cnt;
    logic [7:0]       loss_cnt;
    logic [2:0]       state;

    int tests_run = 0;
    int tests_failed = 0;

    pll_lock_ctrl #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(STB_C),
        .MAX_RETRY(MAX_R), .N_DOM(N_DOM), .STAGGER(STAG)
    ) dut (
        .clkin1(clkin1), .rst_n(rst_n), .pll_lock(pll_lock), .restart(restart),
        .pll_rst(pll_rst), .dom_rst_n(dom_rst_n), .ready(ready), .fail(fail),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
    );

    always #5 clkin1 = ~clkin1;

    // Expected {state, dom_rst_n, ready, pll_rst} k edges after WAIT_LOCK entry,
    // with pll_lock raised d cycles after entry (d = -2: synchronized lock already high).
    function automatic logic [9:0] bring_vec(input int k, input int d);
        int s_e, r_e, run_e;
        logic [2:0] st;
        logic [4:0] dm;
        logic rd;
        s_e = d + 3;
        r_e = s_e + STB_C;
        run_e = r_e + STAG * N_DOM + 1;
        dm = '0;
        rd = 1'b0;
        if (k < s_e) st = 3'd1;
        else if (k < r_e) st = 3'd2;
        else if (k < run_e) begin
            st = 3'd3;
            for (int i = 0; i < N_DOM; i++) dm[i] = (k >= r_e + STAG * (i + 1));
        end else begin
            st = 3'd4;
            dm = '1;
            rd = 1'b1;
        end
        return {st, dm, rd, 1'b0};
    endfunction

    task automatic wait_fall(output int n);
        n = 0;
        do begin
            @(negedge clkin1);
            n++;
        end while (pll_rst !== 1'b0 && n < 300);
        if (pll_rst !== 1'b0) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_pll_rst_fall: pll_rst=%b still high after %0d cycles", pll_rst, n);
        end
    endtask

    task automatic run_bringup(input int d, input string tag);
        int run_e;
        logic [9:0] exp_v, got;
        run_e = d + 3 + STB_C + STAG * N_DOM + 1;
        if (d == 0) pll_lock = 1'b1;
        for (int k = 1; k <= run_e + 2; k++) begin
            @(negedge clkin1);
            exp_v = bring_vec(k, d);
            got = {state, dom_rst_n, ready, pll_rst};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL %s k=%0d {state,dom,ready,pll_rst} got=%b exp=%b", tag, k, got, exp_v);
            end
            if (k == d) pll_lock = 1'b1;
        end
        tests_run++;
        if (retry_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL %s_retry got=%0d exp=0", tag, retry_cnt);
        end
    endtask

    task automatic do_restart(input logic lock_val);
        pll_lock = lock_val;
        restart = 1'b1;
        @(negedge clkin1);
        restart = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clkin1);
        tests_run++;
        if ({state, pll_rst, dom_rst_n, ready, fail} !== {3'd0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b exp=%b", {state, pll_rst, dom_rst_n, ready, fail},
                     {3'd0, 1'b1, 5'd0, 1'b0, 1'b0});
        end
        tests_run++;
        if ({retry_cnt, loss_cnt} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_cnts retry=%0d loss=%0d exp 0/0", retry_cnt, loss_cnt);
        end
    endtask

    task automatic test_bringup;
        int n;
        rst_n = 1'b1;
        wait_fall(n);
        tests_run++;
        if (n != RST_C) begin
            tests_failed++;
            $display("FAIL bringup_pll_rst_len got=%0d exp=%0d", n, RST_C);
        end
        run_bringup(10, "bringup");
        tests_run++;
        if ({loss_cnt, fail} !== 9'd0) begin
            tests_failed++;
            $display("FAIL bringup_flags loss=%0d fail=%b exp 0/0", loss_cnt, fail);
        end
    endtask

    task automatic test_lock_never;
        int n, fail_e, m, r, hold;
        logic [12:0] exp_v, got;
        do_restart(1'b0);
        tests_run++;
        if ({state, pll_rst, dom_rst_n, ready, fail, retry_cnt} !== {3'd0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL restart_from_run got=%b", {state, pll_rst, dom_rst_n, ready, fail, retry_cnt});
        end
        wait_fall(n);
        tests_run++;
        if (n != RST_C) begin
            tests_failed++;
            $display("FAIL restart_pll_rst_len got=%0d exp=%0d", n, RST_C);
        end
        fail_e = (MAX_R + 1) * TO_C + MAX_R * RST_C;
        for (int k = 1; k <= fail_e + 6; k++) begin
            @(negedge clkin1);
            m = k % (TO_C + RST_C);
            r = k / (TO_C + RST_C);
            if (k >= fail_e) exp_v = {3'd5, 1'b1, 1'b1, 4'(MAX_R), 5'd0};
            else if (m < TO_C) exp_v = {3'd1, 1'b0, 1'b0, 4'(r), 5'd0};
            else exp_v = {3'd0, 1'b1, 1'b0, 4'(r + 1), 5'd0};
            got = {state, pll_rst, fail, retry_cnt, dom_rst_n};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL timeout k=%0d {state,pll_rst,fail,retry,dom} got=%b exp=%b", k, got, exp_v);
            end
        end
        pll_lock = 1'b1;
        hold = $urandom_range(10, 40);
        for (int k = 0; k < hold; k++) begin
            @(negedge clkin1);
            tests_run++;
            if ({state, fail, pll_rst, dom_rst_n} !== {3'd5, 1'b1, 1'b1, 5'd0}) begin
                tests_failed++;
                $display("FAIL fail_sticky k=%0d got=%b", k, {state, fail, pll_rst, dom_rst_n});
            end
        end
        do_restart(1'b1);
        tests_run++;
        if ({state, fail, retry_cnt, pll_rst} !== {3'd0, 1'b0, 4'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL fail_restart got=%b exp=%b", {state, fail, retry_cnt, pll_rst}, {3'd0, 1'b0, 4'd0, 1'b1});
        end
        wait_fall(n);
        run_bringup(-2, "after_fail");
    endtask

    task automatic test_chatter;
        int n, d, c, s_e, w2;
        logic [15:0] exp_v, got;
        do_restart(1'b0);
        wait_fall(n);
        d = $urandom_range(0, 10);
        c = $urandom_range(0, 5);
        s_e = d + 3;
        w2 = s_e + c + 3;
        if (d == 0) pll_lock = 1'b1;
        for (int k = 1; k <= w2; k++) begin
            @(negedge clkin1);
            exp_v = {(k >= s_e && k < w2) ? 3'd2 : 3'd1, 5'd0, 8'd0};
            got = {state, dom_rst_n, loss_cnt};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL chatter k=%0d d=%0d c=%0d got=%b exp=%b", k, d, c, got, exp_v);
            end
            if (k == d) pll_lock = 1'b1;
            if (k == s_e + c) pll_lock = 1'b0;
        end
        run_bringup($urandom_range(0, 10), "relock");
        tests_run++;
        if (loss_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL chatter_loss got=%0d exp=0", loss_cnt);
        end
    endtask

    task automatic test_loss_run;
        int n;
        logic [17:0] exp_v, got;
        repeat ($urandom_range(0, 5)) @(negedge clkin1);
        pll_lock = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clkin1);
            if (j < 3) exp_v = {3'd4, 5'h1F, 1'b1, 1'b0, 8'd0};
            else exp_v = {3'd0, 5'h00, 1'b0, 1'b1, 8'd1};
            got = {state, dom_rst_n, ready, pll_rst, loss_cnt};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL loss_react j=%0d got=%b exp=%b", j, got, exp_v);
            end
        end
        pll_lock = 1'b1;
        wait_fall(n);
        tests_run++;
        if (n != RST_C) begin
            tests_failed++;
            $display("FAIL loss_pll_rst_len got=%0d exp=%0d", n, RST_C);
        end
        run_bringup(-2, "reseq");
        for (int i = 2; i <= 256; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clkin1);
            pll_lock = 1'b0;
            repeat (3) @(negedge clkin1);
            tests_run++;
            if (loss_cnt !== 8'((i > 255) ? 255 : i)) begin
                tests_failed++;
                $display("FAIL loss_count i=%0d got=%0d", i, loss_cnt);
            end
            pll_lock = 1'b1;
            n = 0;
            while (ready !== 1'b1 && n < 80) begin
                @(negedge clkin1);
                n++;
            end
            if (ready !== 1'b1) begin
                tests_run++; tests_failed++;
                $display("FAIL loss_relock_timeout i=%0d ready=%b", i, ready);
            end
        end
    endtask

    task automatic test_async_reset;
        int n;
        pll_lock = 1'b0;
        repeat (3) @(negedge clkin1);
        pll_lock = 1'b1;
        wait_fall(n);
        n = 0;
        while (dom_rst_n !== 5'b00111 && n < 80) begin
            @(negedge clkin1);
            n++;
        end
        tests_run++;
        if (dom_rst_n !== 5'b00111 || state !== 3'd3) begin
            tests_failed++;
            $display("FAIL arst_reach_release dom=%b state=%0d", dom_rst_n, state);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({state, pll_rst, dom_rst_n, ready, fail, retry_cnt, loss_cnt} !==
            {3'd0, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL arst_immediate got=%b", {state, pll_rst, dom_rst_n, ready, fail, retry_cnt, loss_cnt});
        end
        @(negedge clkin1);
        rst_n = 1'b1;
        wait_fall(n);
        tests_run++;
        if (n != RST_C) begin
            tests_failed++;
            $display("FAIL arst_pll_rst_len got=%0d exp=%0d", n, RST_C);
        end
        run_bringup(-2, "post_arst");
    endtask

    task automatic test_restart_collide;
        int n;
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin1);
        restart = 1'b1;
        @(negedge clkin1);
        restart = 1'b0;
        tests_run++;
        if ({state, dom_rst_n, ready, pll_rst, loss_cnt} !== {3'd0, 5'd0, 1'b0, 1'b1, 8'd0}) begin
            tests_failed++;
            $display("FAIL restart_collide got=%b", {state, dom_rst_n, ready, pll_rst, loss_cnt});
        end
        pll_lock = 1'b1;
        wait_fall(n);
        run_bringup(-2, "collide_reseq");
    endtask

    task automatic test_restart_release;
        int n;
        do_restart(1'b1);
        wait_fall(n);
        n = 0;
        while (dom_rst_n !== 5'b00011 && n < 80) begin
            @(negedge clkin1);
            n++;
        end
        if (dom_rst_n !== 5'b00011) begin
            tests_run++; tests_failed++;
            $display("FAIL restart_release_reach dom=%b", dom_rst_n);
        end
        restart = 1'b1;
        @(negedge clkin1);
        restart = 1'b0;
        tests_run++;
        if ({state, dom_rst_n, ready} !== {3'd0, 5'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL restart_release got=%b exp=%b", {state, dom_rst_n, ready}, {3'd0, 5'd0, 1'b0});
        end
        repeat (2) @(negedge clkin1);
        restart = 1'b1;
        @(negedge clkin1);
        restart = 1'b0;
        wait_fall(n);
        tests_run++;
        if (n != RST_C) begin
            tests_failed++;
            $display("FAIL restart_in_reset_len got=%0d exp=%0d", n, RST_C);
        end
        run_bringup(-2, "final");
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_never();
        test_chatter();
        test_loss_run();
        test_async_reset();
        test_restart_collide();
        test_restart_release();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
